// File: rtl/alu_pkg.sv
// Shared definitions for the byte-wide ALU and the multi-byte sequencer in front of it.
// Op codes are the {i3,i4,i5} select values decoded by the alu.
package alu_pkg;

  localparam int IDX_W = 2;
  localparam int CNT_W = 2;

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUBR  = 3'b001;
  localparam logic [2:0] ALU_OP_SUBS  = 3'b010;
  localparam logic [2:0] ALU_OP_OR    = 3'b011;
  localparam logic [2:0] ALU_OP_AND   = 3'b100;
  localparam logic [2:0] ALU_OP_NOTRS = 3'b101;
  localparam logic [2:0] ALU_OP_EXOR  = 3'b110;
  localparam logic [2:0] ALU_OP_EXNOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } alu_seq_state_t;

endpackage

// File: rtl/alu_seq_byte_mux.sv
// Byte lane selection for the sequencer: reads byte rd_idx of the latched operands
// and writes one result byte into lane wr_idx of the accumulating result.
module alu_seq_byte_mux
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic [8*NBYTES-1:0] res,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [7:0]          wr_byte,
  output logic [7:0]          a_byte,
  output logic [7:0]          b_byte,
  output logic [8*NBYTES-1:0] res_nxt
);

  always_comb begin
    a_byte  = '0;
    b_byte  = '0;
    res_nxt = res;
    for (int k = 0; k < NBYTES; k++) begin
      if (rd_idx == IDX_W'(k)) begin
        a_byte = a[8*k +: 8];
        b_byte = b[8*k +: 8];
      end
      if (wr_idx == IDX_W'(k)) begin
        res_nxt[8*k +: 8] = wr_byte;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-byte arithmetic sequencer: feeds one wide op through the 8-bit alu LSB first,
// chaining carry between bytes and folding per-byte flags into a registered response.
module alu_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 2,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  input  logic                req_c_in,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_result,
  output logic                rsp_carry,
  output logic                rsp_overflow,
  output logic                rsp_zero,
  output logic                alu_en,
  output logic                alu_i3,
  output logic                alu_i4,
  output logic                alu_i5,
  output logic                alu_c_in,
  output logic [7:0]          alu_r,
  output logic [7:0]          alu_s,
  input  logic [7:0]          alu_f,
  input  logic                alu_zero,
  input  logic                alu_c_out,
  input  logic                alu_overflow
);

  localparam int W = 8 * NBYTES;

  alu_seq_state_t   state, state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic [IDX_W-1:0] byte_cnt;
  logic [IDX_W-1:0] byte_nxt;
  logic [W-1:0]     a_q, b_q, res_q, res_nxt;
  logic             carry_q, ovf_q, zero_q;
  logic [7:0]       a_byte, b_byte;
  logic             accept, capture, last_byte;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign capture   = (state == DRIVE) && (settle_cnt == CNT_W'(SETTLE - 1));
  assign last_byte = (byte_cnt == IDX_W'(NBYTES - 1));
  assign byte_nxt  = byte_cnt + 1'b1;

  alu_seq_byte_mux #(
    .NBYTES (NBYTES)
  ) u_byte_mux (
    .a       (a_q),
    .b       (b_q),
    .res     (res_q),
    .rd_idx  (byte_nxt),
    .wr_idx  (byte_cnt),
    .wr_byte (~alu_f),
    .a_byte  (a_byte),
    .b_byte  (b_byte),
    .res_nxt (res_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   if (capture && last_byte) state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Control and alu drive registers; byte 0 is loaded straight from the request at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt   <= '0;
      byte_cnt     <= '0;
      alu_en       <= 1'b0;
      alu_i3       <= 1'b0;
      alu_i4       <= 1'b0;
      alu_i5       <= 1'b0;
      alu_c_in     <= 1'b0;
      alu_r        <= '0;
      alu_s        <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_en                   <= 1'b1;
            {alu_i3, alu_i4, alu_i5} <= req_op;
            alu_c_in                 <= req_c_in;
            alu_r                    <= req_a[7:0];
            alu_s                    <= req_b[7:0];
            settle_cnt               <= '0;
            byte_cnt                 <= '0;
          end
        end
        DRIVE: begin
          if (capture) begin
            settle_cnt <= '0;
            if (last_byte) begin
              alu_en   <= 1'b0;
              alu_c_in <= 1'b0;
              alu_r    <= '0;
              alu_s    <= '0;
              byte_cnt <= '0;
            end else begin
              alu_c_in <= alu_c_out;
              alu_r    <= a_byte;
              alu_s    <= b_byte;
              byte_cnt <= byte_nxt;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid    <= 1'b1;
            rsp_result   <= res_q;
            rsp_carry    <= carry_q;
            rsp_overflow <= ovf_q;
            rsp_zero     <= zero_q;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand latch and per-byte accumulation; alu_f is only looked at on a capture edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= req_a;
      b_q    <= req_b;
      zero_q <= 1'b1;
    end else if (capture) begin
      res_q   <= res_nxt;
      carry_q <= alu_c_out;
      ovf_q   <= alu_overflow;
      zero_q  <= zero_q & alu_zero;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural byte-wide alu attached to its initiator side.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_c_in;
  logic [2:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry, rsp_overflow, rsp_zero;
  logic         alu_en, alu_i3, alu_i4, alu_i5, alu_c_in;
  logic [7:0]   alu_r, alu_s, alu_f;
  logic         alu_zero, alu_c_out, alu_overflow;

  int errors = 0;
  int checks = 0;

  alu_seq #(.NBYTES(NB), .SETTLE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_c_in     (req_c_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .alu_en       (alu_en),
    .alu_i3       (alu_i3),
    .alu_i4       (alu_i4),
    .alu_i5       (alu_i5),
    .alu_c_in     (alu_c_in),
    .alu_r        (alu_r),
    .alu_s        (alu_s),
    .alu_f        (alu_f),
    .alu_zero     (alu_zero),
    .alu_c_out    (alu_c_out),
    .alu_overflow (alu_overflow)
  );

  always #5 clk = ~clk;

  // Behavioural byte alu: active-low F, flags on the true-polarity result.
  logic [7:0] m_x, m_y, m_res;
  logic [8:0] m_sum;
  logic       m_arith;
  always_comb begin
    m_x     = alu_r;
    m_y     = alu_s;
    m_arith = 1'b1;
    m_res   = '0;
    m_sum   = '0;
    case ({alu_i3, alu_i4, alu_i5})
      ALU_OP_ADD:  begin m_x = alu_r; m_y = alu_s;  end
      ALU_OP_SUBR: begin m_x = alu_s; m_y = ~alu_r; end
      ALU_OP_SUBS: begin m_x = alu_r; m_y = ~alu_s; end
      default:     m_arith = 1'b0;
    endcase
    if (m_arith) begin
      m_sum = {1'b0, m_x} + {1'b0, m_y} + {8'd0, alu_c_in};
      m_res = m_sum[7:0];
    end else begin
      case ({alu_i3, alu_i4, alu_i5})
        ALU_OP_OR:    m_res = alu_r | alu_s;
        ALU_OP_AND:   m_res = alu_r & alu_s;
        ALU_OP_NOTRS: m_res = ~alu_r & alu_s;
        ALU_OP_EXOR:  m_res = alu_r ^ alu_s;
        default:      m_res = ~(alu_r ^ alu_s);
      endcase
    end
    alu_f        = alu_en ? ~m_res : 8'hzz;
    alu_zero     = (m_res == 8'h00);
    alu_c_out    = m_arith & m_sum[8];
    alu_overflow = m_arith & (m_x[7] == m_y[7]) & (m_res[7] != m_x[7]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  vec_t vecs[11];
  logic cin_log[4];
  int   nlog;
  int   lat;

  // Present a request just after an edge and hold it until the accepting edge, then scramble inputs.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_c_in  = cin;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    req_op    = 3'($urandom);
    req_c_in  = 1'($urandom);
  endtask

  task automatic wait_rsp(output int n);
    n    = 0;
    nlog = 0;
    while (!rsp_valid && n < 20) begin
      if (alu_en && nlog < 4) begin
        cin_log[nlog] = alu_c_in;
        nlog++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid still low after %0d cycles", n);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_c_in  = 1'b0;
    rsp_ready = 1'b1;

    vecs[0]  = '{ALU_OP_ADD,  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{ALU_OP_ADD,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{ALU_OP_ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{ALU_OP_ADD,  16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{ALU_OP_SUBS, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{ALU_OP_SUBS, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{ALU_OP_AND,  16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{ALU_OP_AND,  16'hFF00, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{ALU_OP_OR,   16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{ALU_OP_EXOR, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{ALU_OP_ADD,  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    // Reset values, then five idle cycles.
    #2;
    check("rst_alu_en", {31'd0, alu_en}, 32'd0);
    check("rst_alu_drv", {14'd0, alu_r, alu_s, alu_c_in, alu_i3, alu_i4, alu_i5}, 32'd0);
    check("rst_rsp", {15'd0, rsp_valid, rsp_result}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle_state", {29'd0, alu_en, req_ready, rsp_valid}, 32'b010);
    end

    // Table of single operations with rsp_ready held high.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_rsp(lat);
      check($sformatf("v%0d_latency", i), lat, 32'd3);
      check($sformatf("v%0d_result", i), {16'd0, rsp_result}, {16'd0, vecs[i].res});
      check($sformatf("v%0d_flags", i), {29'd0, rsp_carry, rsp_overflow, rsp_zero},
            {29'd0, vecs[i].c, vecs[i].v, vecs[i].z});
      if (i == 0) begin
        check("v0_nbytes_driven", nlog, 32'd2);
        check("v0_byte0_cin", {31'd0, cin_log[0]}, 32'd0);
        check("v0_byte1_cin", {31'd0, cin_log[1]}, 32'd1);
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d_release", i), {30'd0, rsp_valid, req_ready}, 32'b01);
    end

    // Backpressure: response held, a second request waits behind it.
    rsp_ready = 1'b0;
    issue(ALU_OP_ADD, 16'h1234, 16'h0001, 1'b0);
    wait_rsp(lat);
    check("bp_result", {16'd0, rsp_result}, 32'h1235);
    req_op    = ALU_OP_OR;
    req_a     = 16'h0F00;
    req_b     = 16'h00F0;
    req_c_in  = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_ctl", {29'd0, rsp_valid, req_ready, alu_en}, 32'b100);
      check("bp_hold_rsp", {13'd0, rsp_result, rsp_carry, rsp_overflow, rsp_zero},
            {13'd0, 16'h1235, 3'b000});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {30'd0, rsp_valid, req_ready}, 32'b01);
    @(posedge clk);
    #1;
    check("bp_second_accept", {30'd0, alu_en, req_ready}, 32'b10);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("bp_second_result", {16'd0, rsp_result}, 32'h0FF0);
    @(posedge clk);
    #1;

    // Reset in the byte-1 drive cycle abandons the operation.
    issue(ALU_OP_ADD, 16'h00FF, 16'h0001, 1'b0);
    @(posedge clk);
    #1;
    check("mid_byte1_en", {31'd0, alu_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", {31'd0, alu_en}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    #3;
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || alu_en) lat++;
    end
    check("mid_rst_no_rsp", lat, 32'd0);
    issue(ALU_OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
    wait_rsp(lat);
    check("post_rst_latency", lat, 32'd3);
    check("post_rst_result", {16'd0, rsp_result}, 32'h8000);
    check("post_rst_flags", {29'd0, rsp_carry, rsp_overflow, rsp_zero}, 32'b010);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
